// File: rtl/mem_arbiter_rr_if.sv
// Bundle of per-CPU I/D request channels and the shared RAM port seen by mem_arbiter_rr.
// slave = arbiter side, master = caches/RAM model side.
interface mem_arbiter_rr_if #(
    parameter int unsigned CPUS = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
);
    logic [CPUS-1:0]    iREN;
    logic [CPUS*AW-1:0] iaddr;
    logic [CPUS-1:0]    dREN;
    logic [CPUS-1:0]    dWEN;
    logic [CPUS*AW-1:0] daddr;
    logic [CPUS*DW-1:0] dstore;
    logic [CPUS-1:0]    iwait;
    logic [CPUS-1:0]    dwait;
    logic [CPUS*DW-1:0] iload;
    logic [CPUS*DW-1:0] dload;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore;
    logic               ramREN;
    logic               ramWEN;
    logic [DW-1:0]      ramload;
    logic [1:0]         ramstate;
    logic               arb_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, arb_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, arb_err
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Grant-locked round-robin arbiter of CPUS I/D channel pairs onto one RAM port (D over I).
// Optional watchdog with sticky arb_err is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter_rr #(
    parameter int unsigned CPUS           = 2,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    mem_arbiter_rr_if.slave  bus
);
    localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   rr_ptr, rr_ptr_nx;
    logic [CW-1:0]   grant_cpu, grant_cpu_nx;
    logic            grant_is_d, grant_is_d_nx;
    logic [CPUS-1:0] d_req, i_req;
    logic            gnt_req, ram_done, complete_c, forced_c, release_c;
    int unsigned     gi;

    // First requester at or after ptr, wrapping modulo CPUS.
    function automatic logic [CW-1:0] pick_rr(input logic [CPUS-1:0] req, input logic [CW-1:0] ptr);
        logic [2*CPUS-1:0] rot;
        logic [CW:0]       sum;
        logic [CW-1:0]     win;
        logic              found;
        rot   = {req, req} >> ptr;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(CPUS); i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (CW+1)'(i);
                if (sum >= (CW+1)'(CPUS)) sum = sum - (CW+1)'(CPUS);
                win   = sum[CW-1:0];
            end
        end
        return win;
    endfunction

    function automatic logic [CW-1:0] next_cpu(input logic [CW-1:0] g);
        if (CPUS == 1 || g == CW'(CPUS - 1)) return '0;
        return g + CW'(1);
    endfunction

    assign d_req      = bus.dREN | bus.dWEN;
    assign i_req      = bus.iREN;
    assign gi         = 32'(grant_cpu);
    assign gnt_req    = grant_is_d ? d_req[grant_cpu] : i_req[grant_cpu];
    assign ram_done   = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
    // Completion is suppressed while RST is held so a reset mid-grant never releases a channel.
    assign complete_c = (state == GRANT) && gnt_req && ram_done && !RST;
    assign release_c  = complete_c || forced_c;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          arb_err_q;

    assign forced_c = (state == GRANT) && gnt_req && !ram_done &&
                      (tmo_cnt == TW'(TIMEOUT_CYCLES)) && !RST;

    // Watchdog counts stalled GRANT cycles; arb_err is sticky until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt   <= '0;
            arb_err_q <= 1'b0;
        end else begin
            if (state != GRANT || release_c || !gnt_req) tmo_cnt <= '0;
            else                                         tmo_cnt <= tmo_cnt + TW'(1);
            if (forced_c) arb_err_q <= 1'b1;
        end
    end

    assign bus.arb_err = arb_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign forced_c       = 1'b0;
    assign bus.arb_err    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_cpu  <= '0;
            grant_is_d <= 1'b0;
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_ptr_nx;
            grant_cpu  <= grant_cpu_nx;
            grant_is_d <= grant_is_d_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        rr_ptr_nx     = rr_ptr;
        grant_cpu_nx  = grant_cpu;
        grant_is_d_nx = grant_is_d;
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = '0;
        bus.ramstore  = '0;
        bus.iwait     = i_req;
        bus.dwait     = d_req;
        bus.iload     = '0;
        bus.dload     = '0;

        case (state)
            IDLE: begin
                if (|d_req) begin
                    state_nx      = GRANT;
                    grant_cpu_nx  = pick_rr(d_req, rr_ptr);
                    grant_is_d_nx = 1'b1;
                end else if (|i_req) begin
                    state_nx      = GRANT;
                    grant_cpu_nx  = pick_rr(i_req, rr_ptr);
                    grant_is_d_nx = 1'b0;
                end
            end
            GRANT: begin
                bus.ramstore = bus.dstore[gi*DW +: DW];
                if (grant_is_d) begin
                    bus.ramaddr = bus.daddr[gi*AW +: AW];
                    bus.ramREN  = bus.dREN[grant_cpu];
                    bus.ramWEN  = bus.dWEN[grant_cpu];
                end else begin
                    bus.ramaddr = bus.iaddr[gi*AW +: AW];
                    bus.ramREN  = bus.iREN[grant_cpu];
                end
                if (!gnt_req) begin
                    state_nx = IDLE;
                end else if (release_c) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = next_cpu(grant_cpu);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Release the granted channel; a forced (watchdog) release returns zero data.
        for (int unsigned c = 0; c < CPUS; c++) begin
            if (release_c && gi == c) begin
                if (grant_is_d) begin
                    bus.dwait[c] = 1'b0;
                    if (complete_c) bus.dload[c*DW +: DW] = bus.ramload;
                end else begin
                    bus.iwait[c] = 1'b0;
                    if (complete_c) bus.iload[c*DW +: DW] = bus.ramload;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed self-checking bench for mem_arbiter_rr with CPUS=2 (watchdog limit 4 when enabled).
module tb_mem_arbiter_rr;
    logic CLK;
    logic RST;
    int   errors;
    int   checks;

    mem_arbiter_rr_if #(.CPUS(2), .AW(32), .DW(32)) bus ();

    mem_arbiter_rr #(.CPUS(2), .AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        bus.iREN = 2'b01;
        tick();
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== 66'h0) begin
            errors++; $display("FAIL rst_ram: got %h expected 0", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore});
        end
        checks++;
        if ({bus.iwait, bus.dwait} !== 4'b0100) begin
            errors++; $display("FAIL rst_wait: got %b expected 0100", {bus.iwait, bus.dwait});
        end
        checks++;
        if ({bus.arb_err, bus.iload, bus.dload} !== 129'h0) begin
            errors++; $display("FAIL rst_err_load: got %h expected 0", {bus.arb_err, bus.iload, bus.dload});
        end
        bus.iREN = 2'b00;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_ifetch();
        bus.iREN         = 2'b01;
        bus.iaddr[31:0]  = 32'h100;
        bus.ramstate     = 2'd1;
        #1;
        checks++;
        if ({bus.ramREN, bus.iwait} !== 3'b001) begin
            errors++; $display("FAIL if_idle: got %b expected 001", {bus.ramREN, bus.iwait});
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload} !== {2'b10, 32'h100, 2'b01, 64'h0}) begin
                errors++; $display("FAIL if_busy%0d: ren=%b addr=%h iwait=%b iload=%h", k, bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
            end
            tick();
        end
        bus.ramstate = 2'd2;
        bus.ramload  = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bus.iwait, bus.iload} !== {2'b00, 64'h0000_0000_DEADBEEF}) begin
            errors++; $display("FAIL if_access: iwait=%b iload=%h expected 00/00000000deadbeef", bus.iwait, bus.iload);
        end
        tick();
        bus.iREN     = 2'b00;
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.iload} !== 97'h0) begin
            errors++; $display("FAIL if_done_idle: ren=%b addr=%h iload=%h expected 0", bus.ramREN, bus.ramaddr, bus.iload);
        end
    endtask

    task automatic test_d_over_i();
        bus.iREN          = 2'b01;
        bus.dWEN          = 2'b10;
        bus.daddr[63:32]  = 32'h200;
        bus.dstore[63:32] = 32'h55;
        #1;
        checks++;
        if ({bus.iwait, bus.dwait, bus.ramWEN} !== 5'b01100) begin
            errors++; $display("FAIL di_idle: got %b expected 01100", {bus.iwait, bus.dwait, bus.ramWEN});
        end
        tick();
        bus.ramstate = 2'd2;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== {2'b01, 32'h200, 32'h55}) begin
            errors++; $display("FAIL di_dgrant: ren=%b wen=%b addr=%h store=%h", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        checks++;
        if ({bus.dwait, bus.iwait} !== 4'b0001) begin
            errors++; $display("FAIL di_dwait: got %b expected 0001", {bus.dwait, bus.iwait});
        end
        tick();
        bus.dWEN     = 2'b00;
        bus.ramstate = 2'd0;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait} !== 4'b0001) begin
            errors++; $display("FAIL di_gap: got %b expected 0001", {bus.ramREN, bus.ramWEN, bus.iwait});
        end
        tick();
        bus.ramstate = 2'd2;
        bus.ramload  = 32'h1234;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload} !== {1'b1, 32'h100, 2'b00, 64'h1234}) begin
            errors++; $display("FAIL di_igrant: ren=%b addr=%h iwait=%b iload=%h", bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
        end
        tick();
        bus.iREN     = 2'b00;
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic [1:0]  exp_wait;
        logic [63:0] exp_load;
        RST = 1'b1;
        tick();
        RST       = 1'b0;
        bus.dREN  = 2'b11;
        bus.daddr = {32'h304, 32'h300};
        bus.ramstate = 2'd2;
        for (int k = 0; k < 8; k++) begin
            bus.ramload = 32'hA000 + 32'(k);
            #1;
            if ((k % 2) == 0) begin
                checks++;
                if ({bus.ramREN, bus.dwait} !== 3'b011) begin
                    errors++; $display("FAIL rr_idle%0d: got %b expected 011", k, {bus.ramREN, bus.dwait});
                end
            end else begin
                if (((k / 2) % 2) == 1) begin
                    exp_addr = 32'h304; exp_wait = 2'b01; exp_load = {bus.ramload, 32'h0};
                end else begin
                    exp_addr = 32'h300; exp_wait = 2'b10; exp_load = {32'h0, bus.ramload};
                end
                checks++;
                if ({bus.ramREN, bus.ramaddr, bus.dwait, bus.dload} !== {1'b1, exp_addr, exp_wait, exp_load}) begin
                    errors++; $display("FAIL rr_grant%0d: addr=%h dwait=%b dload=%h expected %h/%b/%h",
                                       k, bus.ramaddr, bus.dwait, bus.dload, exp_addr, exp_wait, exp_load);
                end
            end
            tick();
        end
        bus.dREN     = 2'b00;
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
    endtask

    task automatic test_abort();
        bus.dREN     = 2'b01;
        bus.ramstate = 2'd2;
        tick();
        tick();
        bus.dREN     = 2'b10;
        bus.ramstate = 2'd1;
        tick();
        #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.dwait} !== {1'b1, 32'h304, 2'b10}) begin
            errors++; $display("FAIL ab_grant: ren=%b addr=%h dwait=%b", bus.ramREN, bus.ramaddr, bus.dwait);
        end
        tick();
        bus.dREN = 2'b00;
        #1;
        checks++;
        if (bus.dwait !== 2'b00) begin
            errors++; $display("FAIL ab_drop: dwait=%b expected 00", bus.dwait);
        end
        tick();
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dload} !== 98'h0) begin
            errors++; $display("FAIL ab_idle: ren=%b wen=%b addr=%h dload=%h", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dload);
        end
        // Pointer must still favour CPU1 after the abort.
        bus.dREN     = 2'b11;
        bus.ramstate = 2'd2;
        tick();
        #1;
        checks++;
        if ({bus.ramaddr, bus.dwait} !== {32'h304, 2'b01}) begin
            errors++; $display("FAIL ab_ptr: addr=%h dwait=%b expected 304/01", bus.ramaddr, bus.dwait);
        end
        tick();
        bus.dREN     = 2'b00;
        bus.ramstate = 2'd0;
    endtask

    task automatic test_reset_mid_grant();
        bus.iREN     = 2'b01;
        bus.ramstate = 2'd2;
        tick();
        tick();
        bus.iREN         = 2'b10;
        bus.iaddr[63:32] = 32'h180;
        bus.ramstate     = 2'd1;
        tick();
        #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h180}) begin
            errors++; $display("FAIL rm_grant: ren=%b addr=%h expected 1/180", bus.ramREN, bus.ramaddr);
        end
        RST          = 1'b1;
        bus.ramstate = 2'd2;
        bus.ramload  = 32'h77;
        #1;
        checks++;
        if ({bus.iwait, bus.iload} !== {2'b10, 64'h0}) begin
            errors++; $display("FAIL rm_no_complete: iwait=%b iload=%h expected 10/0", bus.iwait, bus.iload);
        end
        tick();
        RST      = 1'b0;
        bus.iREN = 2'b00;
        bus.dREN = 2'b11;
        #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== 34'h0) begin
            errors++; $display("FAIL rm_drop: ren=%b wen=%b addr=%h expected 0", bus.ramREN, bus.ramWEN, bus.ramaddr);
        end
        tick();
        #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.dwait} !== {1'b1, 32'h300, 2'b10}) begin
            errors++; $display("FAIL rm_cpu0_first: ren=%b addr=%h dwait=%b", bus.ramREN, bus.ramaddr, bus.dwait);
        end
        tick();
        bus.dREN     = 2'b00;
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.iREN     = 2'b01;
        bus.ramstate = 2'd1;
        bus.ramload  = 32'hCAFE;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({bus.iwait, bus.arb_err} !== 3'b010) begin
                errors++; $display("FAIL to_stall%0d: got %b expected 010", k, {bus.iwait, bus.arb_err});
            end
            tick();
        end
        #1;
        checks++;
        if ({bus.iwait, bus.iload} !== {2'b00, 64'h0}) begin
            errors++; $display("FAIL to_forced: iwait=%b iload=%h expected 00/0", bus.iwait, bus.iload);
        end
        tick();
        bus.iREN = 2'b00;
        #1;
        checks++;
        if ({bus.arb_err, bus.ramREN} !== 2'b10) begin
            errors++; $display("FAIL to_err: got %b expected 10", {bus.arb_err, bus.ramREN});
        end
        tick();
        tick();
        #1;
        checks++;
        if (bus.arb_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky: arb_err=%b expected 1", bus.arb_err);
        end
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
    endtask
`else
    task automatic test_no_timeout();
        bus.iREN     = 2'b01;
        bus.ramstate = 2'd1;
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if ({bus.ramREN, bus.iwait, bus.arb_err} !== 4'b1010) begin
                errors++; $display("FAIL nt_hold%0d: got %b expected 1010", k, {bus.ramREN, bus.iwait, bus.arb_err});
            end
            tick();
        end
        bus.iREN     = 2'b00;
        bus.ramstate = 2'd0;
        tick();
    endtask
`endif

    initial begin
        errors       = 0;
        checks       = 0;
        RST          = 1'b1;
        bus.iREN     = '0;
        bus.iaddr    = '0;
        bus.dREN     = '0;
        bus.dWEN     = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = 2'd0;
        tick();
        test_reset();
        test_ifetch();
        test_d_over_i();
        test_round_robin();
        test_abort();
        test_reset_mid_grant();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised successor to the single-CPU memory controller.
- Arbitrates 2*CPUS request channels onto one RAM port. Each CPU has one I-channel and one D-channel.
- Arbitration is registered and grant-locked, with round-robin fairness between CPUs and data-over-instruction priority.
- Sits between the per-CPU caches and the RAM model.

Parameters:
- CPUS, 2, number of CPUs (1..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  CPUS  instruction read request, per CPU.
- iaddr  in  CPUS*AW  instruction address; CPU c uses slice [c*AW +: AW].
- dREN  in  CPUS  data read request.
- dWEN  in  CPUS  data write request.
- daddr  in  CPUS*AW  data address.
- dstore  in  CPUS*DW  data write value.
- iwait  out  CPUS  instruction stall.
- dwait  out  CPUS  data stall.
- iload  out  CPUS*DW  instruction read data.
- dload  out  CPUS*DW  data read data.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- arb_err  out  1  sticky watchdog error; tied to 0 when MEM_ARB_TIMEOUT_EN is undefined.

Behaviour:
- Channel request: I-channel c requests when iREN[c]=1. D-channel c requests when dREN[c]=1 or dWEN[c]=1.
- FSM states: IDLE, GRANT.
- IDLE:
  - ramREN and ramWEN are 0.
  - If any channel requests, select a winner and register it as grant_cpu and grant_is_d, then go to GRANT next cycle. Otherwise stay in IDLE.
- Winner selection:
  - If any D-channel requests, the winner is the first requesting D-channel at or after rr_ptr, modulo CPUS.
  - Otherwise the winner is the first requesting I-channel at or after rr_ptr.
- GRANT:
  - Drive ramaddr from the granted channel's address. Drive ramstore from dstore of grant_cpu.
  - ramREN = dREN (D-grant) or iREN (I-grant) of grant_cpu.
  - ramWEN = dWEN of grant_cpu on a D-grant, else 0.
- Completion (GRANT and ramstate==ACCESS or ERROR):
  - The granted channel's wait goes to 0 that cycle and its load output = ramload.
  - Next cycle: return to IDLE and set rr_ptr = (grant_cpu+1) mod CPUS.
- Abort: if the granted channel drops its request while in GRANT, return to IDLE next cycle with rr_ptr unchanged. There is no completion in that case.
- Wait outputs: every requesting channel sees wait=1 except the granted channel in its completion cycle. Non-requesting channels see wait=0.
- Load outputs: all loads are 0 except the completing channel's.
- Latency:
  - Minimum 2 cycles from request to completion (IDLE, then GRANT with ACCESS).
  - Back-to-back requests cost one IDLE cycle between grants.
- Same CPU with both iREN and dREN: the D-channel wins. The I-channel is served on a later arbitration.
- In GRANT, new higher-priority requests do not preempt the current grant.
- Reset:
  - State IDLE, rr_ptr=0, grant_cpu=0, grant_is_d=0, arb_err=0, ramREN=ramWEN=0.
  - ramaddr and ramstore = 0.
  - Waits follow the request rule above; during reset no channel is granted, so a requester sees wait=1.
  - Reset mid-GRANT drops the RAM enables in the next cycle without completion.
- ramaddr and ramstore are 0 while in IDLE.
- CPUS=1: rr_ptr stays 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering GRANT and increments each GRANT cycle without completion.
  - When the counter reaches TIMEOUT_CYCLES, the granted channel gets one forced completion cycle: wait=0, load=0.
  - arb_err sets, the FSM returns to IDLE and rr_ptr advances.
  - arb_err clears only on RST.
- Undefined: no counter, arb_err=0, and GRANT can last indefinitely.

Test Plan (CPUS=2):
- I-read fetch:
  - Stimulus: CPU0 iREN=1, iaddr=0x100; ramstate BUSY 2 cycles, then ACCESS with ramload=0xDEADBEEF.
  - Response: ramaddr=0x100, ramREN=1; iwait[0]=0 and iload[0]=0xDEADBEEF only in the ACCESS cycle.
- D over I:
  - Stimulus: same cycle, CPU0 iREN=1 and CPU1 dWEN=1, daddr=0x200, dstore=0x55.
  - Response: first grant is CPU1 with ramWEN=1, ramstore=0x55; CPU0's I-read follows after one IDLE cycle.
- Round-robin:
  - Stimulus: both CPUs hold dREN=1 continuously, each access with 1-cycle ACCESS.
  - Response: grants alternate CPU0, CPU1, CPU0, CPU1; each completes every 2 cycles.
- Abort:
  - Stimulus: CPU1 dREN dropped mid-GRANT.
  - Response: ramREN=0 next cycle, no dwait release, rr_ptr unchanged.
- Reset mid-GRANT:
  - Stimulus: RST=1 while in GRANT.
  - Response: next cycle ramREN=ramWEN=0 and ramaddr=0; after RST, CPU0 is served first.
- Timeout (MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4):
  - Stimulus: ramstate stuck BUSY.
  - Response: forced release after 4 GRANT cycles; arb_err=1 and stays 1.
